// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pulls bytes from a first-word-fall-through FIFO.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] iv_fifo_dout,
    output logic       o_fifo_rd,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
    localparam int CW       = $clog2(STOP_CYC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          r_par_bit;
    logic          r_txd;
    logic          r_busy;
    logic          r_tx_done;

    logic w_pop;
    logic w_bit_end;
    logic w_stop_end;

    assign w_pop      = (r_state == S_IDLE) && !i_fifo_empty && i_tx_en && !reset;
    assign w_bit_end  = (r_baud == BIT_LAST);
    assign w_stop_end = (r_baud == STOP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_par_bit <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        // Parity is taken from the byte as popped; the FIFO head moves on.
                        r_shreg   <= iv_fifo_dout;
                        r_par_bit <= (PARITY == 1) ? ~(^iv_fifo_dout) : ^iv_fifo_dout;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_txd   <= r_shreg[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shreg <= {1'b0, r_shreg[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_txd     <= r_shreg[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_baud    <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_tx_done <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_rd = w_pop;
    assign o_txd     = r_txd;
    assign o_busy    = r_busy;
    assign o_tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: several parameterisations run side by side, each
// against a frame-offset reference model, with table-driven frames and corner sequences.
module tb_uart_tx_fifo_reader;

    localparam int NI = 5;

    function automatic int cpb_f(input int g);
        return (g == 4) ? 2 : 4;
    endfunction
    function automatic int par_f(input int g);
        case (g)
            1, 4:    return 1;
            2, 3:    return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int sb_f(input int g);
        return (g == 3 || g == 4) ? 2 : 1;
    endfunction
    function automatic int flen_f(input int g);
        return (9 + ((par_f(g) != 0) ? 1 : 0) + sb_f(g)) * cpb_f(g);
    endfunction
    // Expected line value for each bit slot of a frame; unused trailing slots are 1.
    function automatic logic [11:0] frame_bits(input int g, input logic [7:0] d);
        logic [11:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (par_f(g) == 1) b[9] = ~(^d);
        else if (par_f(g) == 2) b[9] = ^d;
        return b;
    endfunction

    logic clk;
    logic [NI-1:0] rst, en, empty, rd, txd, busy, done;
    logic [7:0] dout [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_fifo_reader #(
            .CLKS_PER_BIT(cpb_f(g)),
            .PARITY      (par_f(g)),
            .STOP_BITS   (sb_f(g))
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .i_tx_en     (en[g]),
            .i_fifo_empty(empty[g]),
            .iv_fifo_dout(dout[g]),
            .o_fifo_rd   (rd[g]),
            .o_txd       (txd[g]),
            .o_busy      (busy[g]),
            .o_tx_done   (done[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  fmem [NI][512];
    int          fhd [NI];
    int          ftl [NI];
    bit          m_act [NI];
    int          m_t [NI];
    logic [11:0] m_bits [NI];
    bit          m_done [NI];
    bit          m_rd [NI];
    logic [NI-1:0] o_rd, o_txd_s, o_busy_s, o_done_s;
    int          pops [NI];
    int          dones [NI];

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nb;
        int          len;
    } fvec_t;
    fvec_t tbl [6];

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, g, $time, act, exp);
        end
    endtask

    task automatic refresh(input int g);
        empty[g] = (fhd[g] == ftl[g]);
        dout[g]  = empty[g] ? 8'($urandom) : fmem[g][fhd[g] % 512];
    endtask

    task automatic push(input int g, input logic [7:0] b);
        fmem[g][ftl[g] % 512] = b;
        ftl[g]++;
        refresh(g);
    endtask

    // One clock: compare every instance at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            logic et;
            m_rd[g] = !m_act[g] && (fhd[g] != ftl[g]) && en[g] && !rst[g];
            et = m_act[g] ? m_bits[g][m_t[g] / cpb_f(g)] : 1'b1;
            chk("fifo_rd", g, rd[g], m_rd[g]);
            chk("txd", g, txd[g], et);
            chk("busy", g, busy[g], m_act[g]);
            chk("tx_done", g, done[g], m_done[g]);
            o_rd[g] = rd[g]; o_txd_s[g] = txd[g]; o_busy_s[g] = busy[g]; o_done_s[g] = done[g];
            if (rd[g] === 1'b1) pops[g]++;
            if (done[g] === 1'b1) dones[g]++;
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            m_done[g] = 0;
            if (rst[g]) begin
                m_act[g] = 0;
            end else if (m_act[g]) begin
                m_t[g]++;
                if (m_t[g] == flen_f(g)) begin
                    m_act[g]  = 0;
                    m_done[g] = 1;
                end
            end else if (m_rd[g]) begin
                m_act[g]  = 1;
                m_t[g]    = 0;
                m_bits[g] = frame_bits(g, fmem[g][fhd[g] % 512]);
                fhd[g]++;
            end
            refresh(g);
        end
    endtask

    task automatic wait_pop(input int g);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            tick();
            ok = o_rd[g];
        end
        chk("pop_seen", g, ok, 1);
    endtask

    task automatic capture_frame(input int g, input logic [11:0] exp, input int nb,
                                 input int len, input bit need_wait);
        int d0;
        int c;
        c = cpb_f(g);
        if (need_wait) wait_pop(g);
        d0 = dones[g];
        for (int k = 0; k < len; k++) begin
            tick();
            if ((k % c) == (c / 2) && (k / c) < nb) chk("frame_bit", g, o_txd_s[g], exp[k / c]);
        end
        chk("done_early", g, dones[g] - d0, 0);
        tick();
        chk("done_at_len", g, o_done_s[g], 1);
        chk("busy_end", g, o_busy_s[g], 0);
        chk("idle_txd", g, o_txd_s[g], 1);
    endtask

    initial begin
        int p, d;
        clk = 0;
        rst = '1;
        en  = '0;
        for (int g = 0; g < NI; g++) begin
            fhd[g] = 0; ftl[g] = 0; m_act[g] = 0; m_t[g] = 0; m_bits[g] = '1;
            m_done[g] = 0; m_rd[g] = 0; pops[g] = 0; dones[g] = 0;
            refresh(g);
        end
        repeat (2) @(posedge clk);
        #1;
        tick();
        tick();
        for (int g = 0; g < NI; g++) begin
            chk("reset_txd", g, o_txd_s[g], 1);
            chk("reset_busy", g, o_busy_s[g], 0);
        end
        rst = '0;
        tick();

        tbl[0] = '{0, 8'hA5, 12'hF4A, 10, 40};
        tbl[1] = '{1, 8'hA5, 12'hF4A, 11, 44};
        tbl[2] = '{2, 8'hA5, 12'hD4A, 11, 44};
        tbl[3] = '{1, 8'h00, 12'hE00, 11, 44};
        tbl[4] = '{3, 8'h01, 12'hE02, 12, 48};
        tbl[5] = '{2, 8'h5A, 12'hCB4, 11, 44};
        for (int i = 0; i < 6; i++) begin
            p = pops[tbl[i].inst];
            push(tbl[i].inst, tbl[i].data);
            en[tbl[i].inst] = 1'b1;
            capture_frame(tbl[i].inst, tbl[i].bits, tbl[i].nb, tbl[i].len, 1);
            en[tbl[i].inst] = 1'b0;
            chk("single_pop", tbl[i].inst, pops[tbl[i].inst] - p, 1);
        end

        // Back-to-back frames: the pop lands in the single idle cycle after the first frame.
        p = pops[3];
        push(3, 8'h01);
        push(3, 8'hFF);
        en[3] = 1'b1;
        capture_frame(3, 12'hE02, 12, 48, 1);
        chk("b2b_pop_idle", 3, o_rd[3], 1);
        capture_frame(3, 12'hDFE, 12, 48, 0);
        en[3] = 1'b0;
        repeat (5) tick();
        chk("b2b_pops", 3, pops[3] - p, 2);

        // Empty FIFO with transmit enabled.
        p = pops[0];
        en[0] = 1'b1;
        repeat (100) tick();
        chk("empty_no_pop", 0, pops[0] - p, 0);
        en[0] = 1'b0;

        // Enable dropped during data bit 3.
        push(0, 8'h3C);
        push(0, 8'h5A);
        push(0, 8'h96);
        en[0] = 1'b1;
        wait_pop(0);
        repeat (18) tick();
        en[0] = 1'b0;
        p = pops[0];
        d = dones[0];
        repeat (52) tick();
        chk("no_pop_disabled", 0, pops[0] - p, 0);
        chk("frame_completed", 0, dones[0] - d, 1);
        en[0] = 1'b1;
        tick();
        chk("pop_on_reenable", 0, o_rd[0], 1);
        repeat (41) tick();
        en[0] = 1'b0;

        // Reset during data bit 5: frame dropped, next pop takes the following byte.
        push(2, 8'hC3);
        push(2, 8'h5A);
        en[2] = 1'b1;
        wait_pop(2);
        repeat (25) tick();
        d = dones[2];
        rst[2] = 1'b1;
        tick();
        tick();
        chk("rst_txd", 2, o_txd_s[2], 1);
        chk("rst_busy", 2, o_busy_s[2], 0);
        chk("rst_no_rd", 2, o_rd[2], 0);
        rst[2] = 1'b0;
        en[2]  = 1'b0;
        repeat (50) tick();
        chk("no_done_aborted", 2, dones[2] - d, 0);
        en[2] = 1'b1;
        capture_frame(2, 12'hCB4, 11, 44, 1);
        en[2] = 1'b0;

        // Random traffic, enables and occasional resets, all instances against the model.
        en = '1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int g = 0; g < NI; g++) begin
                if ((ftl[g] - fhd[g]) < 6 && $urandom_range(0, 5) == 0) push(g, 8'($urandom));
                if ($urandom_range(0, 19) == 0) en[g] = ~en[g];
                rst[g] = ($urandom_range(0, 499) == 0);
            end
            tick();
        end
        rst = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-003 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port i_tx_en, input, 1 bit; high permits fetching a new byte from the FIFO.
REQ-007 SHALL have port i_fifo_empty, input, 1 bit; high = the upstream first-word-fall-through FIFO is empty.
REQ-008 SHALL have port iv_fifo_dout, input, 8 bits; head-of-FIFO byte, valid whenever i_fifo_empty is low.
REQ-009 SHALL have port o_fifo_rd, output, 1 bit; one-cycle pop strobe to the FIFO.
REQ-010 SHALL have port o_txd, output, 1 bit; serial line, idle high.
REQ-011 SHALL have port o_busy, output, 1 bit; high while a frame is in progress.
REQ-012 SHALL have port o_tx_done, output, 1 bit; one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive o_fifo_rd combinationally as (state==IDLE) && !i_fifo_empty && i_tx_en; it is never high outside IDLE.
REQ-015 SHALL, on an edge where o_fifo_rd is high, latch iv_fifo_dout into the shift register and enter START.
REQ-016 SHALL register o_txd: low in START, shift-register bit 0 in DATA (LSB first), parity bit in PARITY, high in STOP and IDLE.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles, counted by a baud counter cleared on every state/bit change.
REQ-018 SHALL, in DATA, shift right after each bit; DATA lasts 8 bits, tracked by a 3-bit counter, then the FSM moves to PARITY if PARITY!=0, else to STOP.
REQ-019 SHALL compute the parity bit as XOR of the latched byte (even) or its inverse (odd), from the latched copy, not the live FIFO data.
REQ-020 SHALL hold STOP for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 SHALL pulse o_tx_done for one cycle, coincident with the STOP-to-IDLE transition edge.
REQ-022 SHALL make o_busy high iff state != IDLE (registered).
REQ-023 SHALL make the first falling edge of o_txd appear one cycle after the pop edge.
REQ-024 SHALL make the frame length in cycles exactly (1+8+P+STOP_BITS)*CLKS_PER_BIT, where P = (PARITY!=0).
REQ-025 SHALL, with the FIFO non-empty, insert exactly 1 idle cycle (o_txd high) between consecutive frames: the IDLE cycle in which the pop occurs.
REQ-026 SHALL, if i_tx_en is deasserted mid-frame, complete the current frame and perform no further pops until i_tx_en is high again.
REQ-027 SHALL never pop while i_fifo_empty is high, even if i_tx_en is high.
REQ-028 SHALL ignore changes on iv_fifo_dout and i_fifo_empty outside IDLE.

Reset
REQ-029 SHALL, on reset, set state=IDLE, o_txd=1, o_busy=0, o_tx_done=0, and clear the counters and shift register to 0.
REQ-030 SHALL force o_fifo_rd=0 in any cycle where reset is high.
REQ-031 SHALL, on reset mid-frame, return o_txd high at the next edge; the popped byte is lost and is not re-fetched.
REQ-032 SHALL take reset priority over all other inputs.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 8'hA5, i_tx_en=1 -> one o_fifo_rd pulse; o_txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; o_tx_done 40 cycles after the pop edge.
REQ-034 SHALL cover: PARITY=2 with 8'hA5 -> parity bit 0; PARITY=1 with 8'hA5 -> parity bit 1; frame is 44 cycles.
REQ-035 SHALL cover: FIFO holds 8'h01, 8'hFF back-to-back, STOP_BITS=2 -> exactly two pops; exactly 1 high idle cycle between frames; each frame 48 cycles.
REQ-036 SHALL cover: i_fifo_empty=1 with i_tx_en=1 for 100 cycles -> o_fifo_rd=0, o_txd=1, o_busy=0 throughout.
REQ-037 SHALL cover: i_tx_en dropped in DATA bit 3 -> frame completes normally; no pop afterwards although the FIFO is non-empty; a pop occurs on the first IDLE cycle after re-enable.
REQ-038 SHALL cover: reset asserted in DATA bit 5 -> o_txd=1, o_busy=0 at the next edge; no o_tx_done for the aborted frame; the next pop takes the following FIFO byte.
